poly_mod_canon: RTL

// - Output stage for the modular squaring datapath. Takes a redundant-coefficient polynomial
//   (I_WORD coefs x COEF_BITS, value possibly >= MODULUS) and returns the canonical integer in
//   [0, MODULUS), removing the bench-side "subtract until < mod" loop.
// - Sits between the squarer and the VDF loop/host; valid/ready handshake on both sides.
// - Differs from the squarer wrapper: word-serial carry propagation, bounded iterative

---
 rtl/poly_mod_pkg.sv | 49 ++++
 rtl/poly_mod_cond_sub.sv | 35 +++
 rtl/poly_mod_canon.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/poly_mod_pkg.sv
// Shared types and helpers for the polynomial-to-canonical-integer output stage.
// Bench-side conversion functions use the default 32x32-bit geometry.
package poly_mod_pkg;

  typedef enum logic [1:0] {IDLE, CARRY, SUB, DONE} canon_state_e;

  localparam int DEF_WORD_BITS  = 32;
  localparam int DEF_NUM_WORDS  = 32;
  localparam int DEF_REDUN_BITS = 1;
  localparam int DEF_I_WORD     = DEF_NUM_WORDS + 1;
  localparam int DEF_COEF_BITS  = DEF_WORD_BITS + DEF_REDUN_BITS;
  localparam int DEF_MOD_W      = DEF_WORD_BITS * DEF_NUM_WORDS;

  localparam logic [DEF_MOD_W-1:0] DEF_MODULUS =
    {32'hF1E2_D3C5, {30{32'h9B4A_6C2F}}, 32'h1234_5679};

  // Width of the fully carried value: every word plus the final carry out.
  function automatic int val_bits(input int i_word, input int word_bits, input int redun_bits);
    return i_word * word_bits + redun_bits + 1;
  endfunction

  function automatic int carry_bits(input int redun_bits);
    return redun_bits + 1;
  endfunction

  localparam int DEF_VAL_BITS = val_bits(DEF_I_WORD, DEF_WORD_BITS, DEF_REDUN_BITS);

  typedef logic [DEF_I_WORD-1:0][DEF_COEF_BITS-1:0] poly_t;
  typedef logic [DEF_VAL_BITS-1:0]                  val_t;

  // Top coefficient also absorbs the bits just above the last word.
  function automatic poly_t int_to_poly(input val_t v);
    poly_t p;
    p = '0;
    for (int k = 0; k < DEF_I_WORD - 1; k++)
      p[k] = DEF_COEF_BITS'(v[k*DEF_WORD_BITS +: DEF_WORD_BITS]);
    p[DEF_I_WORD-1] = v[(DEF_I_WORD-1)*DEF_WORD_BITS +: DEF_COEF_BITS];
    return p;
  endfunction

  function automatic val_t poly_to_int(input poly_t p);
    val_t v;
    v = '0;
    for (int k = 0; k < DEF_I_WORD; k++)
      v = v + (val_t'(p[k]) << (k * DEF_WORD_BITS));
    return v;
  endfunction

endpackage

// File: rtl/poly_mod_cond_sub.sv
// Accumulator for the reduction phase: loads the carried value, then subtracts
// the modulus one step at a time; ge is the inverted borrow of that subtraction.
module poly_mod_cond_sub #(
  parameter int                 VAL_W   = 1058,
  parameter int                 MOD_W   = 1024,
  parameter logic [MOD_W-1:0]   MODULUS = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [VAL_W-1:0] i_load_val,
  input  logic             i_sub,
  output logic             o_ge,
  output logic [MOD_W-1:0] o_res
);

  logic [VAL_W-1:0] acc_q, acc_d, diff;
  logic             borrow;

  assign {borrow, diff} = {1'b0, acc_q} - {1'b0, VAL_W'(MODULUS)};
  assign o_ge  = ~borrow;
  assign o_res = acc_q[MOD_W-1:0];

  always_comb begin
    acc_d = acc_q;
    if (i_load)     acc_d = i_load_val;
    else if (i_sub) acc_d = diff;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/poly_mod_canon.sv
// Redundant-coefficient polynomial to canonical integer mod MODULUS: word-serial
// carry resolution followed by bounded conditional subtraction.
module poly_mod_canon
  import poly_mod_pkg::*;
#(
  parameter int WORD_BITS       = DEF_WORD_BITS,
  parameter int NUM_WORDS       = DEF_NUM_WORDS,
  parameter int REDUN_WORD_BITS = DEF_REDUN_BITS,
  parameter int CARRY_WORDS     = 1,
  parameter int MAX_SUB         = 8,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = DEF_MODULUS,
  localparam int I_WORD    = NUM_WORDS + 1,
  localparam int COEF_BITS = WORD_BITS + REDUN_WORD_BITS,
  localparam int CNT_BITS  = $clog2(MAX_SUB + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_val,
  output logic                              o_rdy,
  input  logic [I_WORD-1:0][COEF_BITS-1:0]  i_dat,
  output logic                              o_val,
  input  logic                              i_rdy,
  output logic [NUM_WORDS*WORD_BITS-1:0]    o_dat,
  output logic [CNT_BITS-1:0]               o_sub_cnt,
  output logic                              o_err,
  output canon_state_e                      o_dbg_state
);

  localparam int MOD_W = WORD_BITS * NUM_WORDS;
  localparam int VAL_W = val_bits(I_WORD, WORD_BITS, REDUN_WORD_BITS);
  localparam int CAR_W = carry_bits(REDUN_WORD_BITS);
  localparam int N_CYC = (I_WORD + CARRY_WORDS - 1) / CARRY_WORDS;
  localparam int IDX_W = $clog2(N_CYC + 1);
  localparam int K_W   = $clog2(I_WORD);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid and data stay put until then, and only one transaction is in flight.

  canon_state_e                     state_q;
  logic                             rdy_q, val_q, err_q;
  logic [MOD_W-1:0]                 dat_q;
  logic [CNT_BITS-1:0]              cnt_q;
  logic [IDX_W-1:0]                 idx_q;
  logic [I_WORD-1:0][COEF_BITS-1:0] coef_q;
  logic [I_WORD-1:0][WORD_BITS-1:0] word_q, word_d;
  logic [CAR_W-1:0]                 carry_q, carry_d;
  logic [COEF_BITS:0]               s;
  int                               k;
  logic                             last_carry, load, sub_en, ge;
  logic [MOD_W-1:0]                 res;

  // Resolve this cycle's group of coefficients, carry rippling low to high.
  always_comb begin
    word_d  = word_q;
    carry_d = carry_q;
    s       = '0;
    k       = 0;
    for (int j = 0; j < CARRY_WORDS; j++) begin
      k = int'(idx_q) * CARRY_WORDS + j;
      if (k < I_WORD) begin
        s                 = {1'b0, coef_q[K_W'(k)]} + (COEF_BITS+1)'(carry_d);
        word_d[K_W'(k)]   = s[WORD_BITS-1:0];
        carry_d           = s[COEF_BITS:WORD_BITS];
      end
    end
  end

  assign last_carry = (state_q == CARRY) && (idx_q == IDX_W'(N_CYC - 1));
  assign load       = last_carry;
  assign sub_en     = (state_q == SUB) && ge && (cnt_q != CNT_BITS'(MAX_SUB));

  poly_mod_cond_sub #(
    .VAL_W   (VAL_W),
    .MOD_W   (MOD_W),
    .MODULUS (MODULUS)
  ) u_cond_sub (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_load_val ({carry_d, word_d}),
    .i_sub      (sub_en),
    .o_ge       (ge),
    .o_res      (res)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      coef_q  <= '0;
      word_q  <= '0;
      carry_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_val && rdy_q) begin
          coef_q  <= i_dat;
          word_q  <= '0;
          carry_q <= '0;
          idx_q   <= '0;
          cnt_q   <= '0;
          err_q   <= 1'b0;
          rdy_q   <= 1'b0;
          state_q <= CARRY;
        end
        CARRY: begin
          word_q  <= word_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (last_carry) state_q <= SUB;
        end
        SUB: begin
          // Out of subtraction budget with ge still set: report error, pass raw low bits.
          if (!ge || cnt_q == CNT_BITS'(MAX_SUB)) begin
            err_q   <= ge;
            dat_q   <= res;
            val_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: if (i_rdy) begin
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rdy       = rdy_q;
  assign o_val       = val_q;
  assign o_dat       = dat_q;
  assign o_sub_cnt   = cnt_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule
